// File: rtl/mem.sv
// Memory stage: pipeline register, data-bus request FSM with timeout, store lane
// formatting and load extension. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_INST,
  input  logic        E_VALID,
  input  logic [4:0]  E_REG_D,
  input  logic [31:0] E_ALU_OUT,
  input  logic [31:0] E_STORE_DATA,
  input  logic        E_MEM_RD,
  input  logic        E_MEM_WR,
  input  logic [1:0]  E_MEM_SIZE,
  input  logic        E_MEM_UNS,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_STRB,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_BUSY,
  output logic        M_ERR,
  output logic        M_MISALIGN
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_take, timeout;

  logic [31:0] s_pc, s_inst, s_alu, s_sdata;
  logic        s_valid, s_rd, s_wr, s_uns;
  logic [4:0]  s_reg_d;
  logic [1:0]  s_size;

  logic [31:0] rdata_q, lat_addr, lat_wdata;
  logic [3:0]  lat_strb;
  logic        lat_we, err_q;

  logic        mem_op, misalign, pending, is_load;
  logic [3:0]  fmt_strb;
  logic [31:0] fmt_wdata, ld_res;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_pc <= '0; s_inst <= '0; s_valid <= 1'b0; s_reg_d <= '0;
      s_alu <= '0; s_sdata <= '0; s_rd <= 1'b0; s_wr <= 1'b0;
      s_size <= '0; s_uns <= 1'b0;
    end else if (!STALL) begin
      if (FLUSH) begin
        s_pc <= '0; s_inst <= '0; s_valid <= 1'b0; s_reg_d <= '0;
        s_alu <= '0; s_sdata <= '0; s_rd <= 1'b0; s_wr <= 1'b0;
        s_size <= '0; s_uns <= 1'b0;
      end else begin
        s_pc <= E_PC; s_inst <= E_INST; s_valid <= E_VALID; s_reg_d <= E_REG_D;
        s_alu <= E_ALU_OUT; s_sdata <= E_STORE_DATA; s_rd <= E_MEM_RD; s_wr <= E_MEM_WR;
        s_size <= E_MEM_SIZE; s_uns <= E_MEM_UNS;
      end
    end
  end

  assign mem_op  = s_valid & (s_rd | s_wr);
  assign is_load = s_rd & ~s_wr;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op & (((s_size == 2'd1) & s_alu[0]) | (s_size[1] & (s_alu[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign pending = mem_op & ~misalign & (state_q != S_DONE);

  always_comb begin
    fmt_strb  = 4'b1111;
    fmt_wdata = '0;
    if (s_wr) begin
      fmt_wdata = s_sdata;
      case (s_size)
        2'd0: begin
          fmt_strb  = 4'b0001 << s_alu[1:0];
          fmt_wdata = {4{s_sdata[7:0]}};
        end
        2'd1: begin
          fmt_strb  = 4'b0011 << {s_alu[1], 1'b0};
          fmt_wdata = {2{s_sdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // WAIT drives the bus from a snapshot taken at issue, so it stays stable
  // even if the stage register is disturbed during the access.
  always_comb begin
    DMEM_REQ   = (state_q == S_WAIT) | pending;
    DMEM_WE    = 1'b0;
    DMEM_ADDR  = '0;
    DMEM_STRB  = '0;
    DMEM_WDATA = '0;
    if (state_q == S_WAIT) begin
      DMEM_WE    = lat_we;
      DMEM_ADDR  = lat_addr;
      DMEM_STRB  = lat_strb;
      DMEM_WDATA = lat_wdata;
    end else if (pending) begin
      DMEM_WE    = s_wr;
      DMEM_ADDR  = {s_alu[31:2], 2'b00};
      DMEM_STRB  = fmt_strb;
      DMEM_WDATA = fmt_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_take = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          if (DMEM_ACK) begin
            state_d  = S_DONE;
            ack_take = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (DMEM_ACK) begin
          state_d  = S_DONE;
          ack_take = 1'b1;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!STALL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_strb  <= '0;
      lat_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ack_take) rdata_q <= DMEM_RDATA;
      if (state_q == S_IDLE && pending) begin
        lat_we    <= s_wr;
        lat_addr  <= {s_alu[31:2], 2'b00};
        lat_strb  <= fmt_strb;
        lat_wdata <= fmt_wdata;
      end
      // a timeout on the same edge as a stage update still reports
      if (!STALL) err_q <= 1'b0;
      if (timeout) err_q <= 1'b1;
    end
  end

  always_comb begin
    case (s_alu[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = s_alu[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (s_size)
      2'd0:    ld_res = {{24{ld_byte[7] & ~s_uns}}, ld_byte};
      2'd1:    ld_res = {{16{ld_half[15] & ~s_uns}}, ld_half};
      default: ld_res = rdata_q;
    endcase
  end

  always_comb begin
    M_REG_D_V = s_alu;
    if (state_q == S_DONE && is_load) M_REG_D_V = err_q ? 32'd0 : ld_res;
  end

  assign M_PC       = s_pc;
  assign M_INST     = s_inst;
  assign M_VALID    = s_valid;
  assign M_REG_D    = misalign ? 5'd0 : s_reg_d;
  assign M_BUSY     = DMEM_REQ;
  assign M_ERR      = err_q;
  assign M_MISALIGN = misalign;

endmodule

// File: tb/tb_mem.sv
// Randomized bench for mem: a behavioural model predicts bus activity, latency and
// results per instruction; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem;
  localparam int MAXW = 4;

  logic        CLK, RST, STALL, FLUSH, tb_stall;
  logic [31:0] E_PC, E_INST, E_ALU_OUT, E_STORE_DATA;
  logic        E_VALID, E_MEM_RD, E_MEM_WR, E_MEM_UNS;
  logic [4:0]  E_REG_D;
  logic [1:0]  E_MEM_SIZE;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_STRB;
  logic [31:0] M_PC, M_INST, M_REG_D_V;
  logic        M_VALID, M_BUSY, M_ERR, M_MISALIGN;
  logic [4:0]  M_REG_D;

  int n_vec = 0;
  int n_err = 0;

  mem #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .E_PC(E_PC), .E_INST(E_INST), .E_VALID(E_VALID), .E_REG_D(E_REG_D),
    .E_ALU_OUT(E_ALU_OUT), .E_STORE_DATA(E_STORE_DATA), .E_MEM_RD(E_MEM_RD),
    .E_MEM_WR(E_MEM_WR), .E_MEM_SIZE(E_MEM_SIZE), .E_MEM_UNS(E_MEM_UNS),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_STRB(DMEM_STRB),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_BUSY(M_BUSY), .M_ERR(M_ERR), .M_MISALIGN(M_MISALIGN)
  );

  // the bench plays the pipeline controller: it stalls whenever the stage asks
  assign STALL = M_BUSY | tb_stall;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] load_val(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int nb;
    if (sz == 2'd0) begin
      v  = (w >> (8 * int'(a[1:0]))) % 256;
      nb = 8;
    end else if (sz == 2'd1) begin
      v  = (w >> (16 * int'(a[1]))) % 65536;
      nb = 16;
    end else begin
      return w;
    end
    if (!uns && v >= (32'd1 << (nb - 1))) v = v | (32'hFFFF_FFFF << nb);
    return v;
  endfunction

  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] word,
                        input int lat);
    logic [31:0] pc, inst, exp_v, exp_wd;
    logic [3:0]  exp_strb;
    logic [4:0]  rdst;
    logic        memop, mis, tout;
    int          ncyc, hold;
    pc = $urandom; inst = $urandom; rdst = 5'($urandom);
    E_PC = pc; E_INST = inst; E_VALID = 1'b1; E_REG_D = rdst; E_ALU_OUT = a;
    E_STORE_DATA = d; E_MEM_RD = rd; E_MEM_WR = wr; E_MEM_SIZE = sz; E_MEM_UNS = uns;
    tb_stall = 1'b0;
    tick();
    tb_stall = 1'b1;
    E_PC = $urandom; E_ALU_OUT = $urandom; E_REG_D = 5'($urandom);

    memop = rd | wr;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = memop && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00));
`endif
    tout = (lat > MAXW);
    ncyc = (!memop || mis) ? 0 : (tout ? MAXW + 1 : lat + 1);
    if (!wr)            exp_strb = 4'hF;
    else if (sz == 2'd0) exp_strb = 4'(1 << a[1:0]);
    else if (sz == 2'd1) exp_strb = a[1] ? 4'hC : 4'h3;
    else                 exp_strb = 4'hF;
    if (sz == 2'd0)      exp_wd = d[7:0] * 32'h0101_0101;
    else if (sz == 2'd1) exp_wd = d[15:0] * 32'h0001_0001;
    else                 exp_wd = d;
    if (rd && !wr && memop && !mis) exp_v = tout ? 32'd0 : load_val(sz, uns, a, word);
    else                            exp_v = a;

    chk("misalign", M_MISALIGN, mis);
    for (int c = 0; c < ncyc; c++) begin
      chk("req", DMEM_REQ, 1);
      chk("busy", M_BUSY, 1);
      chk("addr", DMEM_ADDR, a & 32'hFFFF_FFFC);
      chk("we", DMEM_WE, wr);
      chk("strb", DMEM_STRB, exp_strb);
      if (wr) chk("wdata", DMEM_WDATA, exp_wd);
      DMEM_ACK   = (c == lat);
      DMEM_RDATA = DMEM_ACK ? word : $urandom;
      tick();
      DMEM_ACK = 1'b0;
    end
    chk("req_end", DMEM_REQ, 0);
    chk("busy_end", M_BUSY, 0);
    chk("err", M_ERR, memop && !mis && tout);
    chk("pc", M_PC, pc);
    chk("inst", M_INST, inst);
    chk("valid", M_VALID, 1);
    chk("reg_d", M_REG_D, mis ? 5'd0 : rdst);
    chk("reg_d_v", M_REG_D_V, exp_v);
    // extra controller stall: results hold and a flush is ignored
    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      FLUSH = 1'($urandom);
      tick();
      chk("hold_valid", M_VALID, 1);
      chk("hold_reg_d_v", M_REG_D_V, exp_v);
      chk("hold_err", M_ERR, memop && !mis && tout);
    end
    FLUSH = 1'b0;
  endtask

  task automatic flush_step();
    E_VALID = 1'b1; E_PC = $urandom; E_ALU_OUT = $urandom; E_MEM_RD = 1'b1;
    tb_stall = 1'b0; FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; tb_stall = 1'b1;
    chk("flush_valid", M_VALID, 0);
    chk("flush_pc", M_PC, 0);
    chk("flush_req", DMEM_REQ, 0);
    chk("flush_reg_d_v", M_REG_D_V, 0);
    chk("flush_err", M_ERR, 0);
  endtask

  initial begin
    RST = 1'b0; FLUSH = 1'b0; tb_stall = 1'b1;
    E_PC = '0; E_INST = '0; E_VALID = 1'b0; E_REG_D = '0; E_ALU_OUT = '0;
    E_STORE_DATA = '0; E_MEM_RD = 1'b0; E_MEM_WR = 1'b0; E_MEM_SIZE = '0; E_MEM_UNS = 1'b0;
    DMEM_ACK = 1'b0; DMEM_RDATA = '0;
    tick(); tick();
    chk("rst_req", DMEM_REQ, 0);
    chk("rst_busy", M_BUSY, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_reg_d_v", M_REG_D_V, 0);
    chk("rst_strb", DMEM_STRB, 0);
    RST = 1'b1;
    tick();

    run_op(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0);  // LB
    run_op(1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 0);  // LBU
    run_op(0, 1, 2'd1, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 3);  // SH
    run_op(1, 0, 2'd2, 0, 32'h4000, 32'h0, 32'h1234_5678, 99); // LW timeout
    flush_step();
    run_op(0, 1, 2'd2, 0, 32'h3001, 32'hCAFE_F00D, 32'h0, 1);  // SW misaligned
    run_op(0, 0, 2'd0, 0, 32'h5555_AAAA, 32'h0, 32'h0, 0);      // non-memory

    // reset mid-WAIT
    E_PC = $urandom; E_VALID = 1'b1; E_ALU_OUT = 32'h6000; E_MEM_RD = 1'b1; E_MEM_WR = 1'b0;
    E_MEM_SIZE = 2'd2; tb_stall = 1'b0;
    tick();
    tb_stall = 1'b1;
    tick(); tick();
    chk("pre_rst_req", DMEM_REQ, 1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_req", DMEM_REQ, 0);
    chk("mid_rst_valid", M_VALID, 0);
    chk("mid_rst_busy", M_BUSY, 0);
    chk("mid_rst_pc", M_PC, 0);
    #2 RST = 1'b1;
    tick();

    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) flush_step();
      else run_op(kind <= 4, kind >= 5 && kind <= 8, 2'($urandom_range(0, 2)), 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom_range(0, MAXW + 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, the number of cycles a data access waits for DMEM_ACK before it is abandoned.
REQ-002 SHALL have ports CLK (in, 1, the single clock) and RST (in, 1, asynchronous, active-low reset).
REQ-003 SHALL have pipeline control inputs STALL (in, 1, hold the stage register) and FLUSH (in, 1, clear the stage register).
REQ-004 SHALL have execute-stage inputs E_PC (32), E_INST (32), E_VALID (1), E_REG_D (5), E_ALU_OUT (32, result or address), E_STORE_DATA (32), E_MEM_RD (1), E_MEM_WR (1), E_MEM_SIZE (2: 0=byte, 1=half, 2=word) and E_MEM_UNS (1, zero-extend loads).
REQ-005 SHALL have data-bus ports DMEM_REQ (out, 1), DMEM_WE (out, 1), DMEM_ADDR (out, 32), DMEM_STRB (out, 4), DMEM_WDATA (out, 32), DMEM_ACK (in, 1) and DMEM_RDATA (in, 32).
REQ-006 SHALL have outputs M_PC (32), M_INST (32), M_VALID (1), M_REG_D (5), M_REG_D_V (32), M_BUSY (1, stall request to the controller), M_ERR (1, access timed out) and M_MISALIGN (1).

Function
REQ-007 On each CLK edge, the stage register SHALL behave as follows: if STALL=1 it holds; else if FLUSH=1 it clears all fields to 0 with VALID=0; otherwise it loads all E_* inputs.
REQ-008 A memory op is pending when latched VALID=1, (MEM_RD or MEM_WR)=1, and the FSM is not in DONE.
REQ-009 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-010 IDLE with a pending op: DMEM_REQ=1 combinationally in the first cycle; DMEM_ACK=1 leads to DONE, otherwise to WAIT.
REQ-011 WAIT: DMEM_REQ and all DMEM_* outputs SHALL be held stable; a wait counter increments each cycle.
REQ-012 WAIT: DMEM_ACK=1 leads to DONE; counter=MAX_WAIT without ACK leads to DONE with the M_ERR flag set.
REQ-013 DONE SHALL return to IDLE on the first edge with STALL=0, whether that edge loads or flushes.
REQ-014 M_BUSY SHALL be 1 while a memory op is pending (IDLE with an op, or WAIT) and 0 otherwise; non-memory instructions add 0 cycles.
REQ-015 STALL/FLUSH SHALL NOT abort an issued access; the FSM advances regardless of STALL.
REQ-016 DMEM_ADDR SHALL be {ALU_OUT[31:2],2'b00}, and DMEM_WE SHALL equal MEM_WR.
REQ-017 Byte stores: STRB=4'b0001<<a[1:0] and WDATA={4{data[7:0]}}.
REQ-018 Half stores: STRB=4'b0011<<{a[1],1'b0} and WDATA={2{data[15:0]}}.
REQ-019 Word stores: STRB=4'b1111.
REQ-020 Loads SHALL use STRB=4'b1111.
REQ-021 On ACK for a load, RDATA SHALL be captured; the selected byte or half (per a[1:0]) is sign- or zero-extended per MEM_UNS to give the load result.
REQ-022 M_REG_D_V SHALL be the load result for loads in DONE, 0 for timed-out loads, and ALU_OUT otherwise.
REQ-023 M_PC, M_INST, M_VALID and M_REG_D SHALL be driven directly from the stage register.
REQ-024 M_ERR SHALL be 1 from DONE-by-timeout until the stage register next changes.

Reset
REQ-025 RST=0 SHALL immediately clear the stage register, FSM (to IDLE), wait counter, captured data and flags, without waiting for a clock edge.
REQ-026 During reset, every output SHALL be 0, including DMEM_REQ and M_BUSY.
REQ-027 Reset asserted mid-access SHALL drop DMEM_REQ immediately; the bus slave tolerates an abandoned request.

Configuration
REQ-028 With MEM_MISALIGN_TRAP_EN defined, a half access with a[0]=1 or a word access with a[1:0]!=0 is misaligned and SHALL: issue no request, set M_BUSY=0 and M_MISALIGN=1, and force M_REG_D=0.
REQ-029 Without MEM_MISALIGN_TRAP_EN, M_MISALIGN SHALL be tied to 0 and the ignored low address bits SHALL be treated as 0 (half uses a[1]; word uses byte lane 0).

Verification
REQ-030 LB at 0x1003 with RDATA=0x80FFFFFF and ACK in the first cycle -> M_BUSY high for 1 cycle, M_REG_D_V=0xFFFFFF80; the LBU variant gives 0x00000080.
REQ-031 SH data 0x0000BEEF at 0x2002 with ACK after 3 cycles -> STRB=4'b1100, WDATA=0xBEEFBEEF, ADDR=0x2000 stable for 4 cycles, M_BUSY high for 4 cycles.
REQ-032 LW with ACK never asserted and MAX_WAIT=4 -> DONE after 5 request cycles, M_ERR=1, M_REG_D_V=0.
REQ-033 STALL=1 held 3 cycles after ACK -> M_REG_D_V is held; FLUSH while STALL=1 is ignored; next load after STALL=0 restarts in IDLE.
REQ-034 RST=0 pulsed mid-WAIT -> DMEM_REQ=0 and M_VALID=0 before the next CLK edge.
REQ-035 With the macro defined, SW at 0x3001 -> no DMEM_REQ, M_MISALIGN=1, M_REG_D=0; without the macro -> ADDR=0x3000, STRB=4'b1111.
